display_scan_controller: RTL and testbench

DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

---
 rtl/display_scan_controller.sv | 116 +++++++++++
 tb/tb_display_scan_controller.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/display_scan_controller.sv
// Two-digit multiplexed 7-segment scanner for a Gray-coded 4-bit switch value,
// with a debounced push-button that toggles a freeze (hold) of the displayed value.
module display_scan_controller #(
    parameter int REFRESH_CYCLES  = 27000,
    parameter int DEBOUNCE_CYCLES = 270000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] gray_in,
    input  logic       btn_in,
    output logic [3:0] led,
    output logic [6:0] seg,
    output logic       an_uni,
    output logic       an_dec,
    output logic       hold
);
    localparam int RW = (REFRESH_CYCLES  > 1) ? $clog2(REFRESH_CYCLES)  : 1;
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    typedef enum logic {S_UNI, S_DEC} state_t;

    function automatic logic [6:0] pat(input logic [3:0] d);
        case (d)
            4'd0:    pat = 7'b1111110;
            4'd1:    pat = 7'b0110000;
            4'd2:    pat = 7'b1101101;
            4'd3:    pat = 7'b1111001;
            4'd4:    pat = 7'b0110011;
            4'd5:    pat = 7'b1011011;
            4'd6:    pat = 7'b1011111;
            4'd7:    pat = 7'b1110000;
            4'd8:    pat = 7'b1111111;
            4'd9:    pat = 7'b1111011;
            default: pat = 7'b0000000;
        endcase
    endfunction

    logic [3:0]    gray_s1_q, gray_s2_q, value_q, value_d, bin;
    logic          btn_s1_q, btn_s2_q, db_lvl_q, db_lvl_d, hold_q, hold_d;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic [RW-1:0] ref_cnt_q, ref_cnt_d;
    logic          tick, tens, an_uni_q, an_uni_d, an_dec_q, an_dec_d;
    logic [3:0]    units;
    logic [6:0]    seg_q, seg_d;
    state_t        state_q, state_d;

    always_comb begin
        bin[3] = gray_s2_q[3];
        bin[2] = bin[3] ^ gray_s2_q[2];
        bin[1] = bin[2] ^ gray_s2_q[1];
        bin[0] = bin[1] ^ gray_s2_q[0];
        // pre-edge hold decides the load, so the press edge still captures a value
        value_d = hold_q ? value_q : bin;

        tens  = (value_q >= 4'd10);
        units = tens ? (value_q - 4'd10) : value_q;

        tick      = (ref_cnt_q == RW'(REFRESH_CYCLES - 1));
        ref_cnt_d = tick ? '0 : ref_cnt_q + RW'(1);
        state_d   = state_q;
        if (tick) state_d = (state_q == S_UNI) ? S_DEC : S_UNI;
        an_uni_d = (state_d == S_UNI);
        an_dec_d = (state_d == S_DEC);
        // digit pattern follows the next state so segments and anode switch together
        if (state_d == S_UNI) seg_d = pat(units);
        else                  seg_d = tens ? pat(4'd1) : 7'b0000000;

        db_lvl_d = db_lvl_q;
        db_cnt_d = db_cnt_q + DW'(1);
        if (btn_s2_q == db_lvl_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
            db_lvl_d = btn_s2_q;
            db_cnt_d = '0;
        end
        hold_d = hold_q ^ (db_lvl_d & ~db_lvl_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gray_s1_q <= '0;
            gray_s2_q <= '0;
            value_q   <= '0;
            btn_s1_q  <= 1'b0;
            btn_s2_q  <= 1'b0;
            db_lvl_q  <= 1'b0;
            db_cnt_q  <= '0;
            hold_q    <= 1'b0;
            ref_cnt_q <= '0;
            state_q   <= S_UNI;
            an_uni_q  <= 1'b1;
            an_dec_q  <= 1'b0;
            seg_q     <= 7'b1111110;
        end else begin
            gray_s1_q <= gray_in;
            gray_s2_q <= gray_s1_q;
            value_q   <= value_d;
            btn_s1_q  <= btn_in;
            btn_s2_q  <= btn_s1_q;
            db_lvl_q  <= db_lvl_d;
            db_cnt_q  <= db_cnt_d;
            hold_q    <= hold_d;
            ref_cnt_q <= ref_cnt_d;
            state_q   <= state_d;
            an_uni_q  <= an_uni_d;
            an_dec_q  <= an_dec_d;
            seg_q     <= seg_d;
        end
    end

    assign led    = value_q;
    assign seg    = seg_q;
    assign an_uni = an_uni_q;
    assign an_dec = an_dec_q;
    assign hold   = hold_q;
endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller with short refresh/debounce periods.
module tb_display_scan_controller;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] gray_in = 4'b0000;
    logic       btn_in = 1'b0;
    logic [3:0] led;
    logic [6:0] seg;
    logic       an_uni, an_dec, hold;

    int total = 0;
    int bad = 0;
    int both_hi = 0;

    display_scan_controller #(.REFRESH_CYCLES(4), .DEBOUNCE_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .gray_in(gray_in), .btn_in(btn_in),
        .led(led), .seg(seg), .an_uni(an_uni), .an_dec(an_dec), .hold(hold)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (an_uni && an_dec) both_hi++;

    typedef struct {
        logic [3:0] gray;
        logic [3:0] led;
        logic [6:0] seg_u;
        logic [6:0] seg_d;
    } vec_t;
    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_dig(input bit want_dec);
        int n = 0;
        while (!(want_dec ? an_dec : an_uni) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("wait_anode", {31'd0, (want_dec ? an_dec : an_uni)}, 32'd1);
    endtask

    // called right after rst release on a negedge: checks slot timing and led latency
    task automatic check_slots(input logic [3:0] exp_led);
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("slot_uni_%0d", i), {31'd0, an_uni}, {31'd0, ((i / 4) % 2) == 0});
            chk($sformatf("slot_dec_%0d", i), {31'd0, an_dec}, {31'd0, ((i / 4) % 2) == 1});
            if (i == 2) chk("led_lat2", {28'd0, led}, 32'd0);
            if (i == 3) chk("led_lat3", {28'd0, led}, {28'd0, exp_led});
        end
    endtask

    task automatic press(input int n);
        btn_in = 1'b1;
        step(n);
        btn_in = 1'b0;
    endtask

    initial begin
        logic [3:0] prev;
        vecs[0]  = '{4'b1101, 4'd9,  7'b1111011, 7'b0000000};
        vecs[1]  = '{4'b1111, 4'd10, 7'b1111110, 7'b0110000};
        vecs[2]  = '{4'b0000, 4'd0,  7'b1111110, 7'b0000000};
        vecs[3]  = '{4'b0001, 4'd1,  7'b0110000, 7'b0000000};
        vecs[4]  = '{4'b1000, 4'd15, 7'b1011011, 7'b0110000};
        vecs[5]  = '{4'b0110, 4'd4,  7'b0110011, 7'b0000000};
        vecs[6]  = '{4'b0111, 4'd5,  7'b1011011, 7'b0000000};
        vecs[7]  = '{4'b0101, 4'd6,  7'b1011111, 7'b0000000};
        vecs[8]  = '{4'b0100, 4'd7,  7'b1110000, 7'b0000000};
        vecs[9]  = '{4'b1100, 4'd8,  7'b1111111, 7'b0000000};
        vecs[10] = '{4'b0011, 4'd2,  7'b1101101, 7'b0000000};
        vecs[11] = '{4'b0010, 4'd3,  7'b1111001, 7'b0000000};
        vecs[12] = '{4'b1110, 4'd11, 7'b0110000, 7'b0110000};
        vecs[13] = '{4'b1010, 4'd12, 7'b1101101, 7'b0110000};
        vecs[14] = '{4'b1011, 4'd13, 7'b1111001, 7'b0110000};
        vecs[15] = '{4'b1001, 4'd14, 7'b0110011, 7'b0110000};
        vecs[16] = '{4'b1111, 4'd10, 7'b1111110, 7'b0110000};

        // reset state while rst is held
        #12;
        chk("rst_led",   {28'd0, led}, 32'd0);
        chk("rst_uni",   {31'd0, an_uni}, 32'd1);
        chk("rst_dec",   {31'd0, an_dec}, 32'd0);
        chk("rst_seg",   {25'd0, seg}, {25'd0, 7'b1111110});
        chk("rst_hold",  {31'd0, hold}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check_slots(4'd0);

        prev = 4'd0;
        for (int v = 0; v < 17; v++) begin
            gray_in = vecs[v].gray;
            step(2);
            chk($sformatf("led_old_%0d", v), {28'd0, led}, {28'd0, prev});
            step(1);
            chk($sformatf("led_new_%0d", v), {28'd0, led}, {28'd0, vecs[v].led});
            step(2);
            wait_dig(1'b0);
            chk($sformatf("seg_uni_%0d", v), {25'd0, seg}, {25'd0, vecs[v].seg_u});
            wait_dig(1'b1);
            chk($sformatf("seg_dec_%0d", v), {25'd0, seg}, {25'd0, vecs[v].seg_d});
            prev = vecs[v].led;
        end

        // short press is filtered out
        press(5);
        step(20);
        chk("short_hold", {31'd0, hold}, 32'd0);
        // long press freezes the display
        press(12);
        chk("long_hold", {31'd0, hold}, 32'd1);
        step(15);
        chk("release_hold", {31'd0, hold}, 32'd1);
        gray_in = 4'b0001;
        step(6);
        chk("frozen_led", {28'd0, led}, 32'd10);
        press(12);
        chk("unhold", {31'd0, hold}, 32'd0);
        chk("unfrozen_led", {28'd0, led}, 32'd1);
        step(15);

        // freeze again, then reset mid-slot
        press(12);
        step(15);
        chk("hold_again", {31'd0, hold}, 32'd1);
        gray_in = 4'b1111;
        wait_dig(1'b1);
        step(1);
        #2 rst = 1'b1;
        #1;
        chk("mrst_led",  {28'd0, led}, 32'd0);
        chk("mrst_uni",  {31'd0, an_uni}, 32'd1);
        chk("mrst_dec",  {31'd0, an_dec}, 32'd0);
        chk("mrst_seg",  {25'd0, seg}, {25'd0, 7'b1111110});
        chk("mrst_hold", {31'd0, hold}, 32'd0);
        step(2);
        rst = 1'b0;
        check_slots(4'd10);
        chk("post_hold", {31'd0, hold}, 32'd0);

        chk("never_both", both_hi, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
